// File: rtl/switch_debouncer_pkg.sv
// Shared types and constants for the switch debouncer and its event channel.
package switch_debouncer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } evt_state_t;

    localparam int DEFAULT_STABLE_CYCLES = 1000;
    localparam int SIM_STABLE_CYCLES     = 4;
    localparam int MAX_WIDTH             = 16;

    // Counter width able to hold 0..stable_cycles.
    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Change-event channel: valid/ready record plus the sticky overrun flag and its clear.
interface switch_debouncer_if #(
    parameter int WIDTH = 3
);
    logic             evt_valid;
    logic             evt_ready;
    logic [WIDTH-1:0] evt_value;
    logic [WIDTH-1:0] evt_rise;
    logic [WIDTH-1:0] evt_fall;
    logic             evt_overrun;
    logic             clr_overrun;

    modport master (
        output evt_valid,
        output evt_value,
        output evt_rise,
        output evt_fall,
        output evt_overrun,
        input  evt_ready,
        input  clr_overrun
    );

    modport slave (
        input  evt_valid,
        input  evt_value,
        input  evt_rise,
        input  evt_fall,
        input  evt_overrun,
        output evt_ready,
        output clr_overrun
    );
endinterface

// File: rtl/switch_debouncer_debounce_bit.sv
// One switch bit: two-flop synchronizer, stability counter and the committed clean level.
module debounce_bit
    import switch_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = cnt_width(STABLE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic commit
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             clean_q;
    logic             clean_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter holds the number of differing samples already seen, so the
    // commit fires combinationally on the STABLE_CYCLES-th one.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        commit  = 1'b0;
        if (sync_q != clean_q) begin
            if (cnt_q == LAST_CNT) begin
                commit  = 1'b1;
                clean_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            clean_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= raw;
            sync_q  <= meta_q;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clean = clean_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH raw switches and publishes committed changes as a one-deep event record.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int WIDTH         = 3,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    switch_debouncer_if.master evt
);

    localparam int CNT_W = cnt_width(STABLE_CYCLES);

    logic [WIDTH-1:0] commit;
    logic [WIDTH-1:0] new_clean;
    logic [WIDTH-1:0] fresh_rise;
    logic [WIDTH-1:0] fresh_fall;
    logic             any_commit;
    logic             handshake;

    evt_state_t       state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             overrun_q, overrun_d;
    logic             overrun_set;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            debounce_bit #(
                .STABLE_CYCLES(STABLE_CYCLES),
                .CNT_W        (CNT_W)
            ) u_bit (
                .clk   (clk),
                .reset (reset),
                .raw   (sw_raw[gi]),
                .clean (sw_clean[gi]),
                .commit(commit[gi])
            );
        end
    endgenerate

    // A commit always flips its bit, so the post-edge clean vector is an XOR.
    assign new_clean  = sw_clean ^ commit;
    assign fresh_rise = commit & new_clean;
    assign fresh_fall = commit & ~new_clean;
    assign any_commit = |commit;
    assign handshake  = (state_q == PEND) && evt.evt_ready;

    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        rise_d      = rise_q;
        fall_d      = fall_q;
        overrun_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_commit) begin
                    state_d = PEND;
                    value_d = new_clean;
                    rise_d  = fresh_rise;
                    fall_d  = fresh_fall;
                end
            end
            PEND: begin
                if (any_commit && handshake) begin
                    // The old record is consumed this cycle, so the new one starts clean.
                    value_d = new_clean;
                    rise_d  = fresh_rise;
                    fall_d  = fresh_fall;
                end else if (any_commit) begin
                    value_d     = new_clean;
                    rise_d      = rise_q | fresh_rise;
                    fall_d      = fall_q | fresh_fall;
                    overrun_set = 1'b1;
                end else if (handshake) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        overrun_d = overrun_q;
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (evt.clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            value_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            overrun_q <= overrun_d;
        end
    end

    assign evt.evt_valid   = (state_q == PEND);
    assign evt.evt_value   = value_q;
    assign evt.evt_rise    = rise_q;
    assign evt.evt_fall    = fall_q;
    assign evt.evt_overrun = overrun_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with STABLE_CYCLES=4, WIDTH=3.
module tb_switch_debouncer;
    import switch_debouncer_pkg::*;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_clean;

    switch_debouncer_if #(.WIDTH(W)) evt_if ();

    switch_debouncer #(
        .WIDTH        (W),
        .STABLE_CYCLES(SIM_STABLE_CYCLES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sw_raw  (sw_raw),
        .sw_clean(sw_clean),
        .evt     (evt_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic         rst;
        logic [W-1:0] raw;
        logic         rdy;
        logic         clr;
        logic [W-1:0] clean;
        logic         valid;
        logic [W-1:0] value;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         ov;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [W-1:0] raw, input logic rdy, input logic clr,
                       input logic [W-1:0] clean, input logic valid, input logic [W-1:0] value,
                       input logic [W-1:0] rise, input logic [W-1:0] fall, input logic ov);
        vec_t v;
        v.rst = rst; v.raw = raw; v.rdy = rdy; v.clr = clr;
        v.clean = clean; v.valid = valid; v.value = value;
        v.rise = rise; v.fall = fall; v.ov = ov;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] clean, input logic valid,
                         input logic [W-1:0] value, input logic [W-1:0] rise,
                         input logic [W-1:0] fall, input logic ov);
        cmp({tag, ".sw_clean"}, 16'(sw_clean), 16'(clean));
        cmp({tag, ".evt_valid"}, 16'(evt_if.evt_valid), 16'(valid));
        cmp({tag, ".evt_overrun"}, 16'(evt_if.evt_overrun), 16'(ov));
        if (valid) begin
            cmp({tag, ".evt_value"}, 16'(evt_if.evt_value), 16'(value));
            cmp({tag, ".evt_rise"}, 16'(evt_if.evt_rise), 16'(rise));
            cmp({tag, ".evt_fall"}, 16'(evt_if.evt_fall), 16'(fall));
        end
        $display("%s: raw=%b clean=%b valid=%b value=%b rise=%b fall=%b ov=%b", tag, sw_raw,
                 sw_clean, evt_if.evt_valid, evt_if.evt_value, evt_if.evt_rise,
                 evt_if.evt_fall, evt_if.evt_overrun);
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < vecs.size(); i++) begin
            reset              = vecs[i].rst;
            sw_raw             = vecs[i].raw;
            evt_if.evt_ready   = vecs[i].rdy;
            evt_if.clr_overrun = vecs[i].clr;
            step();
            check($sformatf("%s[%0d]", name, i), vecs[i].clean, vecs[i].valid, vecs[i].value,
                  vecs[i].rise, vecs[i].fall, vecs[i].ov);
        end
        vecs.delete();
        evt_if.evt_ready   = 1'b0;
        evt_if.clr_overrun = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        sw_raw             = '0;
        evt_if.evt_ready   = 1'b0;
        evt_if.clr_overrun = 1'b0;

        // Reset, quiet inputs, then a bounce on bit 0 shorter than the window.
        for (int i = 0; i < 2; i++) add(1, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) add(0, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            add(0, ((i / 2) % 2 == 0) ? 3'b001 : 3'b000, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        run_table("quiet");

        // Rise then fall of bit 0 with no consumer: merge and overrun.
        sw_raw = 3'b001;
        repeat (5) step();
        check("t4_pre", 3'b000, 0, 0, 0, 0, 0);
        step();
        check("t4_rise", 3'b001, 1, 3'b001, 3'b001, 3'b000, 0);
        sw_raw = 3'b000;
        repeat (5) step();
        check("t4_hold", 3'b001, 1, 3'b001, 3'b001, 3'b000, 0);
        step();
        check("t4_merge", 3'b000, 1, 3'b000, 3'b001, 3'b001, 1);
        evt_if.clr_overrun = 1'b1;
        step();
        evt_if.clr_overrun = 1'b0;
        check("t4_clr", 3'b000, 1, 3'b000, 3'b001, 3'b001, 0);
        evt_if.evt_ready = 1'b1;
        step();
        evt_if.evt_ready = 1'b0;
        check("t4_ack", 3'b000, 0, 0, 0, 0, 0);

        // 000 -> 101: commit on edge 6, then a one-cycle accept.
        for (int i = 0; i < 5; i++) add(0, 3'b101, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        add(0, 3'b101, 0, 0, 3'b101, 1, 3'b101, 3'b101, 3'b000, 0);
        add(0, 3'b101, 1, 0, 3'b101, 0, 0, 0, 0, 0);
        add(0, 3'b101, 0, 0, 3'b101, 0, 0, 0, 0, 0);
        run_table("rise101");

        // Bit 0 falls (pending), bit 1 commits a rise on the accepting edge.
        sw_raw = 3'b100;
        repeat (2) step();
        sw_raw = 3'b110;
        repeat (4) step();
        check("t5_pend", 3'b100, 1, 3'b100, 3'b000, 3'b001, 0);
        step();
        check("t5_hold", 3'b100, 1, 3'b100, 3'b000, 3'b001, 0);
        evt_if.evt_ready = 1'b1;
        step();
        evt_if.evt_ready = 1'b0;
        check("t5_fresh", 3'b110, 1, 3'b110, 3'b010, 3'b000, 0);

        // Reset while an event is pending discards it.
        sw_raw = 3'b000;
        reset  = 1'b1;
        step();
        check("rst_a", 3'b000, 0, 0, 0, 0, 0);
        step();
        check("rst_b", 3'b000, 0, 0, 0, 0, 0);
        reset = 1'b0;
        repeat (8) step();
        check("rst_after", 3'b000, 0, 0, 0, 0, 0);

        // Reset arriving mid-count restarts the window from the release edge.
        sw_raw = 3'b111;
        repeat (2) step();
        reset = 1'b1;
        step();
        check("t6_rst1", 3'b000, 0, 0, 0, 0, 0);
        step();
        check("t6_rst2", 3'b000, 0, 0, 0, 0, 0);
        reset = 1'b0;
        repeat (5) step();
        check("t6_pre", 3'b000, 0, 0, 0, 0, 0);
        step();
        check("t6_commit", 3'b111, 1, 3'b111, 3'b111, 3'b000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
Input-side counterpart to the switch-to-LED logic. It samples raw board switches, synchronizes them to the system clock and debounces each bit with a stability counter. It publishes the clean switch vector and raises a one-deep change-event record, using a valid/ready handshake, whenever any clean bit commits a new value. Downstream logic (LED decode, mode control) consumes either the level outputs or the events.

Parameters:
WIDTH, 3, number of switch inputs (legal range 1..16)
STABLE_CYCLES, 1000, consecutive differing samples needed to commit a bit (legal range 1 or more)
CNT_W, $clog2(STABLE_CYCLES+1), localparam, width of each per-bit counter

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high reset
sw_raw  in  WIDTH  asynchronous raw switch inputs
sw_clean  out  WIDTH  debounced switch levels
evt_valid  out  1  change event pending
evt_ready  in  1  consumer accepts the event on a cycle where evt_valid and evt_ready are both 1
evt_value  out  WIDTH  sw_clean snapshot of the latest committed change
evt_rise  out  WIDTH  bits that committed 0 to 1
evt_fall  out  WIDTH  bits that committed 1 to 0
evt_overrun  out  1  sticky: a commit arrived while an unaccepted event was pending
clr_overrun  in  1  clears evt_overrun

Behaviour:
- Reset, synchronous and active-high, drives all of these to 0: sync flops, counters, sw_clean, evt_valid, evt_value, evt_rise, evt_fall, evt_overrun. FSM state goes to IDLE.
- Reset mid-operation discards any pending event and any partial count. There is no event for the reset itself.
- Synchronizer: two flops per bit. The second flop is named sync.
- Per-bit debounce, evaluated every clock:
  - If sync equals sw_clean, the counter resets to 0.
  - Otherwise the counter increments.
  - On the STABLE_CYCLES-th consecutive differing sample, sw_clean takes sync, the counter resets to 0, and commit[i] pulses for 1 cycle.
- Latency: the edge that first samples the new sw_raw counts as edge 1. sw_clean changes at edge STABLE_CYCLES+2, and evt_valid rises on that same edge.
- Any mismatch gap, such as a bounce back to the old level, resets the counter to 0. Bounces shorter than STABLE_CYCLES never commit.
- Per-bit counters are independent. Several bits may commit in the same cycle and form one event.
- Counter saturation is not possible: it resets on commit, so CNT_W is sufficient.
- Event FSM, states IDLE and PEND:
  - IDLE, any commit: go to PEND. evt_value = new sw_clean, evt_rise = commit & new, evt_fall = commit & ~new.
  - PEND, handshake and no commit: go to IDLE. evt_valid falls on the next edge.
  - PEND, handshake and a commit in the same cycle: stay in PEND and load the new event fresh, replacing rather than merging. No overrun.
  - PEND, commit without handshake: merge. evt_value = newest sw_clean, evt_rise |= new rises, evt_fall |= new falls, evt_overrun set to 1.
  - PEND, no commit: all evt_* outputs hold, whatever evt_ready is.
- evt_value, evt_rise and evt_fall are valid only while evt_valid is 1. In IDLE they hold their last values.
- clr_overrun clears evt_overrun on the next edge. If a set and a clear occur in the same cycle, the set wins.
- STABLE_CYCLES=1: a bit commits on its first differing sample, giving a latency of 3 edges.

Decomposition:
- Package switch_debouncer_pkg holds:
  - typedef enum logic {IDLE, PEND} evt_state_t
  - localparam DEFAULT_STABLE_CYCLES = 1000
  - localparam SIM_STABLE_CYCLES = 4
- Sub-module debounce_bit, instantiated WIDTH times with a generate loop:
  - contains the 2-flop synchronizer, the counter and the clean bit
  - outputs clean and commit
- The top level contains only the event FSM and the merge logic.

Test Plan (STABLE_CYCLES=4, WIDTH=3):
1. Hold reset for 2 cycles, then keep sw_raw=000 for 20 cycles -> sw_clean=000, evt_valid stays 0.
2. sw_raw 000 to 101 sampled at edge 1, with evt_ready=0 -> at edge 6: sw_clean=101, evt_valid=1, evt_value=101, evt_rise=101, evt_fall=000. Then raise evt_ready for 1 cycle -> evt_valid=0 on the next edge, evt_overrun=0.
3. sw_raw[0] toggles every 2 cycles for 20 cycles, then holds its original value -> no commit, sw_clean unchanged, evt_valid stays 0.
4. evt_ready=0. sw_raw 000 to 001 commits, then sw_raw goes back to 000 and commits 6 cycles later -> evt_value=000, evt_rise=001, evt_fall=001, evt_overrun=1. Pulse clr_overrun -> evt_overrun=0 and evt_valid still 1.
5. With an event pending, assert evt_ready in the exact cycle a new commit of bit 1 (0 to 1) occurs -> evt_valid stays 1 with evt_rise=010, evt_fall=000, and the other bits of the fresh event correct; evt_overrun=0.
6. Reset: sw_raw 000 to 111, assert reset 2 cycles after the change, release reset 2 cycles later while sw_raw holds 111 -> during reset sw_clean=000 and evt_valid=0. sw_clean=111 with evt_rise=111 exactly 6 edges after the release edge, counting the first post-release sample as edge 1.
